// File: rtl/reprog_mem_arbiter_if.sv
// Signal bundle shared by the reprogramming arbiter, its two requesters and the memory port.
// master = arbiter side, slave = requesters plus memory controller.
interface reprog_mem_arbiter_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

   logic [22:0]        prog_addr;
   logic [31:0]        prog_data;
   logic               prog_write;
   logic               cpu_hold;
   logic               cpu_req;
   logic               cpu_we;
   logic [22:0]        cpu_addr;
   logic [31:0]        cpu_wdata;
   logic [31:0]        cpu_rdata;
   logic               cpu_ack;
   logic               mem_req;
   logic               mem_we;
   logic [22:0]        mem_addr;
   logic [31:0]        mem_wdata;
   logic [31:0]        mem_rdata;
   logic               mem_done;
   logic               prog_overflow;
   logic [22:0]        prog_words;
   logic [LEVEL_W-1:0] fifo_level;

   modport master (
      input  prog_addr, prog_data, prog_write,
      input  cpu_hold, cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  mem_rdata, mem_done,
      output cpu_rdata, cpu_ack,
      output mem_req, mem_we, mem_addr, mem_wdata,
      output prog_overflow, prog_words, fifo_level
   );

   modport slave (
      output prog_addr, prog_data, prog_write,
      output cpu_hold, cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output mem_rdata, mem_done,
      input  cpu_rdata, cpu_ack,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      input  prog_overflow, prog_words, fifo_level
   );
endinterface

// File: rtl/reprog_mem_arbiter.sv
// Shares one 32-bit memory port between the UART reprogramming stream and the CPU bus.
// Reprogramming words are de-duplicated by address, queued, and granted with a bounded burst.
module reprog_mem_arbiter #(
   parameter logic [22:0] INIT_ADDR  = 23'h7fffff,
   parameter int          FIFO_DEPTH = 4,
   parameter int          PROG_BURST = 8
) (
   input  logic                 clk_50mhz,
   input  logic                 rst,
   reprog_mem_arbiter_if.master arb_bus
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int BURST_W = $clog2(PROG_BURST + 1);

   typedef enum logic [1:0] {IDLE, PROG, CPU} state_t;

   typedef struct packed {
      logic [22:0] addr;
      logic [31:0] data;
   } prog_word_t;

   state_t               state, state_nxt;
   prog_word_t           fifo_mem [FIFO_DEPTH];
   prog_word_t           fifo_head;
   logic [PTR_W-1:0]     rd_ptr, wr_ptr;
   logic [LVL_W-1:0]     level;
   logic [22:0]          last_addr;
   logic [BURST_W-1:0]   burst_cnt;
   logic                 fifo_empty, fifo_full;
   logic                 cpu_eligible, new_word;
   logic                 grant_prog, grant_cpu;
   logic                 push, pop, drop;

   assign fifo_empty   = (level == '0);
   assign fifo_full    = (level == LVL_W'(FIFO_DEPTH));
   assign fifo_head    = fifo_mem[rd_ptr];
   assign cpu_eligible = arb_bus.cpu_req && !arb_bus.cpu_hold && !arb_bus.cpu_ack;
   assign new_word     = arb_bus.prog_write && (arb_bus.prog_addr != last_addr);

   // The pop reads the registered head, so it never races with this cycle's capture.
   assign pop  = grant_prog;
   assign push = new_word && (!fifo_full || pop);
   assign drop = new_word && fifo_full && !pop;

   assign arb_bus.fifo_level = level;

   always_ff @(posedge clk_50mhz) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      // NOTE: defaults come first so no path through the case leaves a variable unassigned (no latch).
      state_nxt  = state;
      grant_prog = 1'b0;
      grant_cpu  = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty && (burst_cnt < BURST_W'(PROG_BURST) || !cpu_eligible)) begin
               state_nxt  = PROG;
               grant_prog = 1'b1;
            end else if (cpu_eligible) begin
               state_nxt = CPU;
               grant_cpu = 1'b1;
            end
         end
         PROG, CPU: if (arb_bus.mem_done) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // NOTE: the FIFO storage has no reset; occupancy and pointers alone decide what is valid.
   always_ff @(posedge clk_50mhz) begin
      if (push) fifo_mem[wr_ptr] <= '{addr: arb_bus.prog_addr, data: arb_bus.prog_data};
   end

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      level <= level + LVL_W'(1);
         else if (pop && !push) level <= level - LVL_W'(1);
      end
   end

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         arb_bus.mem_req       <= 1'b0;
         arb_bus.mem_we        <= 1'b0;
         arb_bus.mem_addr      <= '0;
         arb_bus.mem_wdata     <= '0;
         arb_bus.cpu_ack       <= 1'b0;
         arb_bus.cpu_rdata     <= '0;
         arb_bus.prog_overflow <= 1'b0;
         arb_bus.prog_words    <= '0;
         last_addr             <= INIT_ADDR;
         burst_cnt             <= '0;
      end else begin
         arb_bus.cpu_ack <= 1'b0;
         last_addr       <= arb_bus.prog_write ? arb_bus.prog_addr : INIT_ADDR;
         if (drop) arb_bus.prog_overflow <= 1'b1;

         if (grant_prog) begin
            arb_bus.mem_req   <= 1'b1;
            arb_bus.mem_we    <= 1'b1;
            arb_bus.mem_addr  <= fifo_head.addr;
            arb_bus.mem_wdata <= fifo_head.data;
            if (burst_cnt != BURST_W'(PROG_BURST)) burst_cnt <= burst_cnt + BURST_W'(1);
         end else if (grant_cpu) begin
            arb_bus.mem_req   <= 1'b1;
            arb_bus.mem_we    <= arb_bus.cpu_we;
            arb_bus.mem_addr  <= arb_bus.cpu_addr;
            arb_bus.mem_wdata <= arb_bus.cpu_wdata;
            burst_cnt         <= '0;
         end
         if (state == IDLE && fifo_empty) burst_cnt <= '0;

         if (state != IDLE && arb_bus.mem_done) begin
            arb_bus.mem_req <= 1'b0;
            if (state == PROG) begin
               arb_bus.prog_words <= arb_bus.prog_words + 23'd1;
            end else begin
               arb_bus.cpu_ack <= 1'b1;
               if (!arb_bus.mem_we) arb_bus.cpu_rdata <= arb_bus.mem_rdata;
            end
         end
      end
   end

endmodule
